// File: rtl/exe_mem_pipe_reg.sv
// EXE/MEM pipeline register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that keeps in_ready free of combinational paths.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | nothing held, outputs zero
// ST_ONE   | main register holds the output entry
// ST_FULL  | main holds the output entry, skid holds the next (older than any new input)
module exe_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int STATUS_W   = 8,
    parameter int MEM_CTRL_W = 3,
    parameter int WB_CTRL_W  = 2,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MEM_CTRL_W-1:0] in_mem_ctrl,
    input  logic [WB_CTRL_W-1:0]  in_wb_ctrl,
    input  logic [STATUS_W-1:0]   in_status,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_rd2,
    input  logic [REG_W-1:0]      in_dst,
    input  logic [DATA_W-1:0]     in_branch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MEM_CTRL_W-1:0] out_mem_ctrl,
    output logic [WB_CTRL_W-1:0]  out_wb_ctrl,
    output logic [STATUS_W-1:0]   out_status,
    output logic [DATA_W-1:0]     out_alu,
    output logic [DATA_W-1:0]     out_rd2,
    output logic [REG_W-1:0]      out_dst,
    output logic [DATA_W-1:0]     out_branch
);

    localparam int ENT_W = MEM_CTRL_W + WB_CTRL_W + STATUS_W + 3 * DATA_W + REG_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   main_q, main_d;
    logic [ENT_W-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [ENT_W-1:0]   in_ent;
    logic               accept;
    logic               take;

    logic [MEM_CTRL_W-1:0] main_mem_ctrl;
    logic [WB_CTRL_W-1:0]  main_wb_ctrl;

    assign in_ent = {in_mem_ctrl, in_wb_ctrl, in_status, in_alu, in_rd2, in_dst, in_branch};

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = SKID_EN ? in_ready_q : (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A simultaneous take has already completed downstream; only the held
            // entries and any incoming entry are discarded.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_ent;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        main_d = in_ent;
                    end else if (accept && SKID_EN) begin
                        skid_d  = in_ent;
                        state_d = ST_FULL;
                    end else if (take) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign {main_mem_ctrl, main_wb_ctrl, out_status, out_alu, out_rd2, out_dst, out_branch} = main_q;

    // Control is gated as well as zero-stored so a bubble can never carry an enable.
    assign out_mem_ctrl = out_valid ? main_mem_ctrl : '0;
    assign out_wb_ctrl  = out_valid ? main_wb_ctrl  : '0;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg: skid (SKID_EN=1) and single-register (SKID_EN=0) instances.
module tb_exe_mem_pipe_reg;

    logic        CLK;
    logic        RST;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_mem_ctrl, out_mem_ctrl;
    logic [1:0]  in_wb_ctrl, out_wb_ctrl;
    logic [7:0]  in_status, out_status;
    logic [31:0] in_alu, out_alu, in_rd2, out_rd2, in_branch, out_branch;
    logic [4:0]  in_dst, out_dst;

    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_alu0, out_alu0, out_rd20, out_branch0;
    logic [2:0]  out_mem_ctrl0;
    logic [1:0]  out_wb_ctrl0;
    logic [7:0]  out_status0;
    logic [4:0]  out_dst0;

    int n_chk = 0;
    int n_fail = 0;

    exe_mem_pipe_reg #(.SKID_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_ctrl(in_mem_ctrl), .in_wb_ctrl(in_wb_ctrl), .in_status(in_status),
        .in_alu(in_alu), .in_rd2(in_rd2), .in_dst(in_dst), .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_ctrl(out_mem_ctrl), .out_wb_ctrl(out_wb_ctrl), .out_status(out_status),
        .out_alu(out_alu), .out_rd2(out_rd2), .out_dst(out_dst), .out_branch(out_branch)
    );

    exe_mem_pipe_reg #(.SKID_EN(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_mem_ctrl(in_mem_ctrl), .in_wb_ctrl(in_wb_ctrl), .in_status(in_status),
        .in_alu(in_alu0), .in_rd2(in_rd2), .in_dst(in_dst), .in_branch(in_branch),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_mem_ctrl(out_mem_ctrl0), .out_wb_ctrl(out_wb_ctrl0), .out_status(out_status0),
        .out_alu(out_alu0), .out_rd2(out_rd20), .out_dst(out_dst0), .out_branch(out_branch0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i);
        in_valid    = v;
        in_alu      = i;
        in_mem_ctrl = i[2:0];
        in_wb_ctrl  = i[1:0];
        in_status   = i[7:0] * 8'd3;
        in_rd2      = ~i;
        in_dst      = i[4:0];
        in_branch   = 32'h1000_0000 + i;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_alu;
    logic        acc, tk;

    initial begin
        RST = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_alu0 = '0; out_ready0 = 1'b0;
        drive(1'b0, 32'd0);

        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu", out_alu, 0);
        tick();
        chk("rst_held_in_ready", in_ready, 1);
        chk("rst_in_ready0", in_ready0, 1);
        #2 RST = 1'b0;

        // streaming, no back-pressure
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_alu", out_alu, i);
            chk("stream_in_ready", in_ready, 1);
            if (i == 5) begin
                chk("field_mem", out_mem_ctrl, 3'd5);
                chk("field_wb", out_wb_ctrl, 2'd1);
                chk("field_status", out_status, 8'd15);
                chk("field_rd2", out_rd2, 32'hFFFF_FFFA);
                chk("field_dst", out_dst, 5'd5);
                chk("field_branch", out_branch, 32'h1000_0005);
            end
        end
        drive(1'b0, 32'd0);
        tick();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_alu", out_alu, 0);

        // back-pressure into the skid buffer
        out_ready = 1'b0;
        drive(1'b1, 32'h11);
        tick();
        chk("bp_a_alu", out_alu, 32'h11);
        chk("bp_a_in_ready", in_ready, 1);
        drive(1'b1, 32'h22);
        tick();
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_hold_alu", out_alu, 32'h11);
        drive(1'b0, 32'd0);
        tick();
        chk("bp_hold2_alu", out_alu, 32'h11);
        chk("bp_hold2_mem", out_mem_ctrl, 3'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_alu", out_alu, 32'h22);
        chk("bp_b_in_ready", in_ready, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // flush with a simultaneous accept
        out_ready = 1'b0;
        drive(1'b1, 32'h33);
        in_mem_ctrl = 3'b101; in_wb_ctrl = 2'b10;
        tick();
        chk("fl_one_mem", out_mem_ctrl, 3'b101);
        drive(1'b1, 32'h44);
        in_mem_ctrl = 3'b011;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0);
        chk("fl_valid", out_valid, 0);
        chk("fl_mem", out_mem_ctrl, 0);
        chk("fl_wb", out_wb_ctrl, 0);
        chk("fl_alu", out_alu, 0);
        out_ready = 1'b1;
        tick();
        chk("fl_dropped", out_valid, 0);

        // flush from FULL releases in_ready the next cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h5);
        tick();
        drive(1'b1, 32'h6);
        tick();
        chk("flf_in_ready", in_ready, 0);
        drive(1'b0, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flf_in_ready_back", in_ready, 1);
        chk("flf_valid", out_valid, 0);

        // asynchronous reset mid-stream
        drive(1'b1, 32'h66);
        tick();
        drive(1'b1, 32'h77);
        tick();
        drive(1'b0, 32'd0);
        chk("rm_full", in_ready, 0);
        #3 RST = 1'b1;
        #1;
        chk("rm_valid", out_valid, 0);
        chk("rm_alu", out_alu, 0);
        chk("rm_mem", out_mem_ctrl, 0);
        chk("rm_in_ready", in_ready, 1);
        #1 RST = 1'b0;
        tick();
        chk("rm_after", out_valid, 0);

        // single-register variant
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_alu0 = 32'h44;
        tick();
        chk("s0_valid", out_valid0, 1);
        chk("s0_alu", out_alu0, 32'h44);
        in_valid0 = 1'b0;
        #1;
        chk("s0_in_ready_low", in_ready0, 0);
        out_ready0 = 1'b1; in_valid0 = 1'b1; in_alu0 = 32'h55;
        #1;
        chk("s0_in_ready_high", in_ready0, 1);
        tick();
        chk("s0_reload_valid", out_valid0, 1);
        chk("s0_reload_alu", out_alu0, 32'h55);
        in_valid0 = 1'b0;
        tick();
        chk("s0_empty", out_valid0, 0);

        // random gaps and stalls: bubbles carry no control, order preserved
        q.delete();
        for (int c = 0; c < 300; c++) begin
            if (!out_valid) chk("bubble_ctrl", {out_mem_ctrl, out_wb_ctrl}, 0);
            drive(1'($urandom_range(0, 1)), $urandom);
            in_mem_ctrl = in_mem_ctrl | 3'b001;
            in_wb_ctrl  = in_wb_ctrl | 2'b01;
            out_ready   = 1'($urandom_range(0, 1));
            #3;
            acc = in_valid & in_ready;
            tk  = out_valid & out_ready;
            if (tk) begin
                if (q.size() == 0) chk("order_underflow", 1, 0);
                else begin
                    exp_alu = q.pop_front();
                    chk("order_alu", out_alu, exp_alu);
                end
            end
            if (acc) q.push_back(in_alu);
            tick();
        end
        drive(1'b0, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (out_valid) begin
                if (q.size() == 0) chk("drain_underflow", 1, 0);
                else begin
                    exp_alu = q.pop_front();
                    chk("drain_alu", out_alu, exp_alu);
                end
            end
            tick();
        end
        chk("drain_count", q.size(), 0);
        chk("drain_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised EXE/MEM pipeline register with valid/ready flow control, synchronous flush and an optional 2-entry skid buffer. Sits between the ALU stage and the data-memory stage. Carries mem/wb control, ALU status, ALU result, store data, destination register and branch target. Adds stall back-pressure and bubble insertion. Control fields are zeroed whenever the output is not valid, so downstream never sees stale mem/wb enables.

Parameters:
DATA_W, 32, width of ALU result, store data and branch address fields
REG_W, 5, width of destination register address
STATUS_W, 8, width of ALU status flags
MEM_CTRL_W, 3, width of memory-stage control
WB_CTRL_W, 2, width of write-back control
SKID_EN, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of all held entries (exception/branch mispredict)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_mem_ctrl  in  MEM_CTRL_W  memory control
in_wb_ctrl  in  WB_CTRL_W  write-back control
in_status  in  STATUS_W  ALU status
in_alu  in  DATA_W  ALU result
in_rd2  in  DATA_W  store data
in_dst  in  REG_W  destination register
in_branch  in  DATA_W  branch target
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts this cycle
out_mem_ctrl, out_wb_ctrl, out_status, out_alu, out_rd2, out_dst, out_branch  out  as inputs  registered copies

Behaviour:
- RST asserted (any time, async): all entries invalid; every out_* = 0; out_valid = 0; in_ready = 1 (also held during reset).
- Accept = in_valid & in_ready; take = out_valid & out_ready.
- Latency: entry accepted in cycle N appears on out_* with out_valid = 1 in cycle N+1.
- out_mem_ctrl/out_wb_ctrl forced to 0 whenever out_valid = 0 (bubble). Data fields also hold 0 when empty.
- While out_valid & ~out_ready, all out_* stay bit-stable.
- SKID_EN = 1, states EMPTY / ONE / FULL (main register, plus skid register when FULL):
  - EMPTY: accept -> ONE.
  - ONE, accept & take: main reloads -> ONE.
  - ONE, accept & ~take: entry goes to skid -> FULL.
  - ONE, ~accept & take: -> EMPTY.
  - FULL, take: skid moves to main -> ONE.
  - FULL, ~take: hold.
  - in_ready = ~FULL, taken directly from a register with no input-to-output combinational path. Order is preserved: skid is always older than any new entry.
- SKID_EN = 0: single register. in_ready = ~out_valid | out_ready (combinational). Simultaneous accept & take reloads the register without a bubble.
- flush: at the next edge all entries become invalid, ctrl outputs become 0, and state becomes EMPTY. flush has priority over a simultaneous accept (the incoming entry is dropped) and over take (the take still counts as completed downstream). in_ready returns to 1 the cycle after flush.
- Widths: pure storage, no arithmetic. All fields are copied bit-exact.

Test Plan:
- Reset mid-stream: fill FULL, pulse RST asynchronously between edges -> out_valid = 0, all out_* = 0 and in_ready = 1 immediately, without waiting for CLK.
- Streaming: out_ready = 1, feed in_alu = 1..8 on consecutive cycles -> out_alu = 1..8 one cycle later, no bubbles, in_ready stays 1.
- Back-pressure (SKID_EN = 1): out_ready = 0 and push A = 0x11, B = 0x22 -> in_ready drops after B and out_alu holds 0x11. Raise out_ready -> 0x11 then 0x22, no loss or duplication, in_ready back to 1.
- Flush with simultaneous accept: state ONE holding mem_ctrl = 3'b101, assert flush and in_valid with mem_ctrl = 3'b011 -> next cycle out_valid = 0, out_mem_ctrl = 0, out_wb_ctrl = 0, and the dropped entry never appears.
- SKID_EN = 0: out_valid = 1, out_ready = 0 -> in_ready = 0 in the same cycle. Set out_ready = 1 together with in_valid and in_alu = 0x55 -> 0x55 appears next cycle with no bubble.
- Bubble check: random in_valid gaps -> whenever out_valid = 0, out_mem_ctrl = 0 and out_wb_ctrl = 0 (assertion held every cycle).
